count_mon_y: RTL

COUNT_MON_Y -- requirements
Module: count_mon_y

---
 rtl/cal_pkg.sv | 27 ++
 rtl/edge_det.sv | 31 +++
 rtl/count_mon_y.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cal_pkg.sv
// cal_pkg -- shared calendar constants for the month/year/century counter.
// Holds field limits, reset load values, the adjust-FSM state encoding and
// the Gregorian leap-year rule used to register the leap flag.
package cal_pkg;

    localparam logic [3:0] MON_MAX = 4'd12;
    localparam logic [3:0] MON_MIN = 4'd1;
    localparam logic [6:0] Y_MAX   = 7'd99;
    localparam logic [6:0] C_MAX   = 7'd99;

    localparam logic [3:0] MON_RST = 4'd1;
    localparam logic [6:0] Y_RST   = 7'd0;
    localparam logic [6:0] C_RST   = 7'd20;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ADJ_MON = 2'd1,
        ADJ_Y   = 2'd2,
        ADJ_C   = 2'd3
    } adj_state_e;

    // Year 0 of a century is a leap year only when the century is divisible by 4.
    function automatic logic is_leap(input logic [6:0] y, input logic [6:0] c);
        return (y[1:0] == 2'b00) && ((y != 7'd0) || (c[1:0] == 2'b00));
    endfunction

endpackage

// File: rtl/edge_det.sv
// edge_det -- registered rising-edge detector with synchronous reset.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, clears both level registers
//   d_i    : level input (debounced button)
//   rise_o : high for one cycle after a registered 0->1 transition
// Both level registers clear on reset, so the first cycle after reset can
// never report an edge even if the button is already held.
module edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic lvl_q;
    logic lvl_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
        end else begin
            lvl_q      <= d_i;
            lvl_prev_q <= lvl_q;
        end
    end

    assign rise_o = lvl_q & ~lvl_prev_q;

endmodule

// File: rtl/count_mon_y.sv
// count_mon_y -- month / year / century counter with button adjust FSM.
// Ports:
//   clk       : single clock, all state on rising edge
//   set_mon   : synchronous active-high reset (loads 1 / 0 / 20, FSM=RUN)
//   pulse_mon : one-cycle month-advance pulse, honoured only in RUN
//   adj_mode  : button level; each rising edge steps RUN->MON->Y->C->RUN
//   adj_inc   : button level; each rising edge bumps the selected field
//   cnt_mon   : month 1..12
//   cnt_y     : year within century 0..99
//   cnt_c     : century 0..99
//   leap      : registered leap flag, aligned with cnt_y/cnt_c
//   pulse_y   : one-cycle pulse on counted year rollover
//   pulse_c   : one-cycle pulse on counted century rollover
//   adj_state : current adjust state (for display blanking)
module count_mon_y
    import cal_pkg::*;
(
    input  logic       clk,
    input  logic       set_mon,
    input  logic       pulse_mon,
    input  logic       adj_mode,
    input  logic       adj_inc,
    output logic [3:0] cnt_mon,
    output logic [6:0] cnt_y,
    output logic [6:0] cnt_c,
    output logic       leap,
    output logic       pulse_y,
    output logic       pulse_c,
    output logic [1:0] adj_state
);

    adj_state_e state_q, state_d;
    logic [3:0] mon_q, mon_d;
    logic [6:0] y_q, y_d;
    logic [6:0] c_q, c_d;
    logic       leap_q, leap_d;
    logic       py_q, py_d;
    logic       pc_q, pc_d;
    logic       mode_rise;
    logic       inc_rise;

    edge_det u_mode_edge (
        .clk_i  (clk),
        .rst_i  (set_mon),
        .d_i    (adj_mode),
        .rise_o (mode_rise)
    );

    edge_det u_inc_edge (
        .clk_i  (clk),
        .rst_i  (set_mon),
        .d_i    (adj_inc),
        .rise_o (inc_rise)
    );

    // State register and counter registers
    always_ff @(posedge clk) begin
        if (set_mon) begin
            state_q <= RUN;
            mon_q   <= MON_RST;
            y_q     <= Y_RST;
            c_q     <= C_RST;
            leap_q  <= is_leap(Y_RST, C_RST);
            py_q    <= 1'b0;
            pc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mon_q   <= mon_d;
            y_q     <= y_d;
            c_q     <= c_d;
            leap_q  <= leap_d;
            py_q    <= py_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (mode_rise) begin
            unique case (state_q)
                RUN:     state_d = ADJ_MON;
                ADJ_MON: state_d = ADJ_Y;
                ADJ_Y:   state_d = ADJ_C;
                ADJ_C:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Counter datapath; counting only in RUN, adjust increments only in ADJ_*
    // and only when no mode step happens in the same cycle.
    always_comb begin
        mon_d = mon_q;
        y_d   = y_q;
        c_d   = c_q;
        py_d  = 1'b0;
        pc_d  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (pulse_mon) begin
                    if (mon_q >= MON_MAX) begin
                        mon_d = MON_MIN;
                        py_d  = 1'b1;
                        if (y_q >= Y_MAX) begin
                            y_d  = '0;
                            pc_d = 1'b1;
                            c_d  = (c_q >= C_MAX) ? '0 : c_q + 7'd1;
                        end else begin
                            y_d = y_q + 7'd1;
                        end
                    end else begin
                        mon_d = mon_q + 4'd1;
                    end
                end
            end
            ADJ_MON: begin
                if (inc_rise && !mode_rise)
                    mon_d = (mon_q >= MON_MAX) ? MON_MIN : mon_q + 4'd1;
            end
            ADJ_Y: begin
                if (inc_rise && !mode_rise)
                    y_d = (y_q >= Y_MAX) ? '0 : y_q + 7'd1;
            end
            ADJ_C: begin
                if (inc_rise && !mode_rise)
                    c_d = (c_q >= C_MAX) ? '0 : c_q + 7'd1;
            end
            default: ;
        endcase
        leap_d = is_leap(y_d, c_d);
    end

    // Output logic
    always_comb begin
        adj_state = state_q;
        cnt_mon   = mon_q;
        cnt_y     = y_q;
        cnt_c     = c_q;
        leap      = leap_q;
        pulse_y   = py_q;
        pulse_c   = pc_q;
    end

endmodule
